// File: rtl/multi_operand_accumulator.sv
// multi_operand_accumulator: frame-based signed/unsigned multi-operand adder fed by a valid/ready stream
// Ports:
//   clk, rst_b            clock (rising edge), asynchronous active-low reset
//   start, n_ops          begin a frame of n_ops operands (clamped to MAX_OPS), sampled in IDLE
//   signed_mode           1 = two's-complement operands, sampled with start
//   op_valid, op_data     operand stream input
//   op_ready              operand accepted this cycle when high together with op_valid
//   busy                  frame in progress
//   count                 operands accepted in the current/last frame
//   sum, sum_valid, ovf   widened sum, one-cycle final strobe, does-not-fit-in-W flag
module multi_operand_accumulator #(
    parameter int W       = 8,
    parameter int MAX_OPS = 16,
    parameter int CW      = $clog2(MAX_OPS + 1),
    parameter int SW      = W + $clog2(MAX_OPS)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          start,
    input  logic [CW-1:0] n_ops,
    input  logic          signed_mode,
    input  logic          op_valid,
    input  logic [W-1:0]  op_data,
    output logic          op_ready,
    output logic          busy,
    output logic [CW-1:0] count,
    output logic [SW-1:0] sum,
    output logic          sum_valid,
    output logic          ovf
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] nlim, n_clamp, count_nxt;
    logic [SW-1:0] ext, sum_nxt;
    logic          sgn, xfer, last;
    assign n_clamp   = n_ops > CW'(MAX_OPS) ? CW'(MAX_OPS) : n_ops;
    assign xfer      = op_valid && state == ACC;
    assign count_nxt = count + 1'b1;
    assign last      = count_nxt == nlim;
    // sign bit replicated only in signed mode, otherwise zero-extension
    assign ext       = {{(SW-W){sgn & op_data[W-1]}}, op_data};
    assign sum_nxt   = sum + ext;
    assign op_ready  = state == ACC;
    assign busy      = state != IDLE;
    assign sum_valid = state == DONE;
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state == IDLE ? (start ? (|n_clamp ? ACC : DONE) : IDLE) :
                    state == ACC  ? (xfer && last ? DONE : ACC) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            nlim  <= '0;
            sgn   <= 1'b0;
            sum   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (state == IDLE && start) begin
            nlim  <= n_clamp;
            sgn   <= signed_mode;
            sum   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (xfer) begin
            sum   <= sum_nxt;
            count <= count_nxt;
            // signed result fits in W bits only if all bits from W-1 upward agree
            if (last) ovf <= sgn ? !(&sum_nxt[SW-1:W-1] || ~|sum_nxt[SW-1:W-1]) : |sum_nxt[SW-1:W];
        end
    end
endmodule
